// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: FP issue scoreboard with in-order result tag FIFO, write-back steering and drain control
module fp_issue_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int NUM_FPR = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dec_valid_i,
  output logic dec_ready_o,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic [4:0] dec_rs3_i,
  input  logic [2:0] dec_src_en_i,
  input  logic [4:0] dec_rd_i,
  input  logic dec_fp_wr_i,
  input  logic dec_int_wr_i,
  output logic fpu_in_valid_o,
  input  logic fpu_in_ready_i,
  input  logic fpu_out_valid_i,
  output logic fpu_out_ready_o,
  output logic wb_fp_we_o,
  output logic [4:0] wb_fp_waddr_o,
  output logic wb_int_we_o,
  output logic [4:0] wb_int_waddr_o,
  input  logic drain_i,
  output logic drain_done_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic error_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic [NUM_FPR-1:0] sb_q, sb_d;
  logic [6:0] fifo_q [MAX_OUTSTANDING];
  logic [6:0] fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic hazard, full, empty, issue, retire;
  logic [6:0] head;
  always_comb begin
    head = fifo_q[rptr_q];
    hazard = (dec_src_en_i[0] & sb_q[dec_rs1_i]) | (dec_src_en_i[1] & sb_q[dec_rs2_i]) |
             (dec_src_en_i[2] & sb_q[dec_rs3_i]) | (dec_fp_wr_i & sb_q[dec_rd_i]);
    full = cnt_q == CW'(MAX_OUTSTANDING);
    empty = cnt_q == '0;
    fpu_in_valid_o = ~rst_i & (state_q == RUN) & ~drain_i & dec_valid_i & ~hazard & ~full;
    dec_ready_o = fpu_in_valid_o & fpu_in_ready_i;
    issue = dec_ready_o;
    fpu_out_ready_o = ~rst_i & ~empty;
    retire = fpu_out_valid_i & fpu_out_ready_o;
    wb_fp_we_o = retire & head[6];
    wb_int_we_o = retire & head[5];
    wb_fp_waddr_o = rst_i ? '0 : head[4:0];
    wb_int_waddr_o = rst_i ? '0 : head[4:0];
    drain_done_o = ~rst_i & (state_q == DRAIN) & empty;
    outstanding_o = cnt_q;
    error_o = err_q;
    err_d = err_q | (fpu_out_valid_i & empty);
    fifo_d = fifo_q;
    if (issue) fifo_d[wptr_q] = {dec_fp_wr_i, dec_int_wr_i, dec_rd_i};
    wptr_d = issue ? wptr_q + PW'(1) : wptr_q;
    rptr_d = retire ? rptr_q + PW'(1) : rptr_q;
    cnt_d = cnt_q + CW'(issue) - CW'(retire);
    sb_d = sb_q;
    if (retire & head[6]) sb_d[head[4:0]] = 1'b0;
    if (issue & dec_fp_wr_i) sb_d[dec_rd_i] = 1'b1;
    state_d = state_q == RUN ? (drain_i ? DRAIN : RUN) :
              state_q == DRAIN ? (empty ? (drain_i ? HOLD : RUN) : DRAIN) :
              (drain_i ? HOLD : RUN);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      sb_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sb_q <= sb_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk_i) fifo_q <= fifo_d;
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed scenario bench for fp_issue_ctrl
module tb_fp_issue_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;
  logic dec_valid_i, dec_ready_o;
  logic [4:0] dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i;
  logic [2:0] dec_src_en_i;
  logic dec_fp_wr_i, dec_int_wr_i;
  logic fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
  logic wb_fp_we_o, wb_int_we_o;
  logic [4:0] wb_fp_waddr_o, wb_int_waddr_o;
  logic drain_i, drain_done_o, error_o;
  logic [2:0] outstanding_o;
  int n_chk = 0;
  int n_fail = 0;
  fp_issue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rs3_i(dec_rs3_i),
    .dec_src_en_i(dec_src_en_i), .dec_rd_i(dec_rd_i),
    .dec_fp_wr_i(dec_fp_wr_i), .dec_int_wr_i(dec_int_wr_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .wb_fp_we_o(wb_fp_we_o), .wb_fp_waddr_o(wb_fp_waddr_o),
    .wb_int_we_o(wb_int_we_o), .wb_int_waddr_o(wb_int_waddr_o),
    .drain_i(drain_i), .drain_done_o(drain_done_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );
  always #5 clk_i = ~clk_i;
  task step;
    @(posedge clk_i);
    #1;
  endtask
  task op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
          input logic [2:0] en, input logic fp, input logic iw);
    dec_valid_i = 1'b1;
    dec_rd_i = rd;
    dec_rs1_i = rs1;
    dec_rs2_i = rs2;
    dec_rs3_i = rs3;
    dec_src_en_i = en;
    dec_fp_wr_i = fp;
    dec_int_wr_i = iw;
  endtask
  task test_reset;
    rst_i = 1'b1;
    drain_i = 1'b0;
    fpu_in_ready_i = 1'b1;
    fpu_out_valid_i = 1'b0;
    op(5'd1, 5'd2, 5'd3, 5'd0, 3'b011, 1'b1, 1'b0);
    step;
    #1;
    n_chk++; if (fpu_in_valid_o !== 1'b0 || dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_issue: in_valid=%b dec_ready=%b expected 0 0", fpu_in_valid_o, dec_ready_o); end
    n_chk++; if (fpu_out_ready_o !== 1'b0 || drain_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_out: out_ready=%b drain_done=%b expected 0 0", fpu_out_ready_o, drain_done_o); end
    rst_i = 1'b0;
    dec_valid_i = 1'b0;
    #1;
    n_chk++; if (outstanding_o !== 3'd0 || error_o !== 1'b0) begin n_fail++; $display("FAIL reset_state: outstanding=%0d error=%b expected 0 0", outstanding_o, error_o); end
    n_chk++; if (fpu_out_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_empty: out_ready=%b expected 0", fpu_out_ready_o); end
  endtask
  task test_back_to_back;
    step;
    op(5'd1, 5'd2, 5'd3, 5'd0, 3'b011, 1'b1, 1'b0);
    #1;
    n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first: dec_ready=%b expected 1", dec_ready_o); end
    step;
    op(5'd4, 5'd5, 5'd6, 5'd0, 3'b011, 1'b1, 1'b0);
    #1;
    n_chk++; if (dec_ready_o !== 1'b1 || outstanding_o !== 3'd1) begin n_fail++; $display("FAIL b2b_second: dec_ready=%b outstanding=%0d expected 1 1", dec_ready_o, outstanding_o); end
    step;
    op(5'd20, 5'd4, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0);
    #1;
    n_chk++; if (outstanding_o !== 3'd2 || fpu_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_sb4: outstanding=%0d in_valid=%b expected 2 0", outstanding_o, fpu_in_valid_o); end
    dec_rs1_i = 5'd1;
    #1;
    n_chk++; if (fpu_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_sb1: in_valid=%b expected 0", fpu_in_valid_o); end
    dec_valid_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (wb_fp_we_o !== 1'b1 || wb_fp_waddr_o !== 5'd1) begin n_fail++; $display("FAIL b2b_wb1: we=%b addr=%0d expected 1 1", wb_fp_we_o, wb_fp_waddr_o); end
    step;
    n_chk++; if (wb_fp_we_o !== 1'b1 || wb_fp_waddr_o !== 5'd4 || outstanding_o !== 3'd1) begin n_fail++; $display("FAIL b2b_wb4: we=%b addr=%0d outstanding=%0d expected 1 4 1", wb_fp_we_o, wb_fp_waddr_o, outstanding_o); end
    step;
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (outstanding_o !== 3'd0 || wb_fp_we_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done: outstanding=%0d we=%b expected 0 0", outstanding_o, wb_fp_we_o); end
  endtask
  task test_raw;
    step;
    op(5'd1, 5'd2, 5'd3, 5'd0, 3'b011, 1'b1, 1'b0);
    step;
    op(5'd7, 5'd1, 5'd5, 5'd0, 3'b011, 1'b1, 1'b0);
    #1;
    n_chk++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall: dec_ready=%b expected 0", dec_ready_o); end
    step;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (dec_ready_o !== 1'b0 || wb_fp_waddr_o !== 5'd1 || wb_fp_we_o !== 1'b1) begin n_fail++; $display("FAIL raw_nobypass: dec_ready=%b we=%b addr=%0d expected 0 1 1", dec_ready_o, wb_fp_we_o, wb_fp_waddr_o); end
    step;
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_issue: dec_ready=%b expected 1", dec_ready_o); end
    step;
    dec_valid_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (wb_fp_waddr_o !== 5'd7 || outstanding_o !== 3'd1) begin n_fail++; $display("FAIL raw_wb7: addr=%0d outstanding=%0d expected 7 1", wb_fp_waddr_o, outstanding_o); end
    step;
    fpu_out_valid_i = 1'b0;
  endtask
  task test_backpressure;
    op(5'd8, 5'd9, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0);
    fpu_in_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({fpu_in_valid_o, dec_ready_o} !== 2'b10) begin n_fail++; $display("FAIL bp_hold%0d: in_valid,dec_ready=%b expected 10", i, {fpu_in_valid_o, dec_ready_o}); end
      step;
    end
    fpu_in_ready_i = 1'b1;
    #1;
    n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept: dec_ready=%b expected 1", dec_ready_o); end
    step;
    dec_valid_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    step;
    fpu_out_valid_i = 1'b0;
  endtask
  task test_full;
    for (int i = 0; i < 4; i++) begin
      op(5'(11 + i), 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
      #1;
      n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: dec_ready=%b expected 1", i, dec_ready_o); end
      step;
    end
    op(5'd15, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    #1;
    n_chk++; if (dec_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_stall: dec_ready=%b outstanding=%0d expected 0 4", dec_ready_o, outstanding_o); end
    step;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (dec_ready_o !== 1'b0 || wb_fp_waddr_o !== 5'd11) begin n_fail++; $display("FAIL full_retire: dec_ready=%b addr=%0d expected 0 11", dec_ready_o, wb_fp_waddr_o); end
    step;
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (dec_ready_o !== 1'b1 || outstanding_o !== 3'd3) begin n_fail++; $display("FAIL full_issue5: dec_ready=%b outstanding=%0d expected 1 3", dec_ready_o, outstanding_o); end
    step;
    dec_valid_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (wb_fp_we_o !== 1'b1 || wb_fp_waddr_o !== 5'(12 + i)) begin n_fail++; $display("FAIL full_drain%0d: we=%b addr=%0d expected 1 %0d", i, wb_fp_we_o, wb_fp_waddr_o, 12 + i); end
      step;
    end
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL full_empty: outstanding=%0d expected 0", outstanding_o); end
  endtask
  task test_int_wr;
    op(5'd10, 5'd1, 5'd0, 5'd0, 3'b001, 1'b0, 1'b1);
    #1;
    n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL int_issue: dec_ready=%b expected 1", dec_ready_o); end
    step;
    fpu_in_ready_i = 1'b0;
    op(5'd20, 5'd10, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0);
    #1;
    n_chk++; if (fpu_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL int_sb: in_valid=%b expected 1", fpu_in_valid_o); end
    dec_valid_i = 1'b0;
    fpu_in_ready_i = 1'b1;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if ({wb_int_we_o, wb_fp_we_o} !== 2'b10 || wb_int_waddr_o !== 5'd10) begin n_fail++; $display("FAIL int_wb: int_we,fp_we=%b addr=%0d expected 10 10", {wb_int_we_o, wb_fp_we_o}, wb_int_waddr_o); end
    step;
    fpu_out_valid_i = 1'b0;
  endtask
  task test_drain;
    op(5'd16, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    step;
    op(5'd17, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    step;
    op(5'd18, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    drain_i = 1'b1;
    #1;
    n_chk++; if (fpu_in_valid_o !== 1'b0 || outstanding_o !== 3'd2) begin n_fail++; $display("FAIL drain_block: in_valid=%b outstanding=%0d expected 0 2", fpu_in_valid_o, outstanding_o); end
    step;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (drain_done_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_busy: done=%b in_valid=%b expected 0 0", drain_done_o, fpu_in_valid_o); end
    step;
    step;
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (drain_done_o !== 1'b1) begin n_fail++; $display("FAIL drain_done: done=%b expected 1", drain_done_o); end
    step;
    n_chk++; if (drain_done_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_hold: done=%b in_valid=%b expected 0 0", drain_done_o, fpu_in_valid_o); end
    drain_i = 1'b0;
    #1;
    n_chk++; if (fpu_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_hold_exit: in_valid=%b expected 0", fpu_in_valid_o); end
    step;
    n_chk++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_resume: dec_ready=%b expected 1", dec_ready_o); end
    step;
    dec_valid_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    step;
    fpu_out_valid_i = 1'b0;
  endtask
  task test_error;
    fpu_out_valid_i = 1'b1;
    #1;
    n_chk++; if (error_o !== 1'b0 || fpu_out_ready_o !== 1'b0 || wb_fp_we_o !== 1'b0) begin n_fail++; $display("FAIL err_pre: error=%b out_ready=%b we=%b expected 0 0 0", error_o, fpu_out_ready_o, wb_fp_we_o); end
    step;
    fpu_out_valid_i = 1'b0;
    #1;
    n_chk++; if (error_o !== 1'b1 || outstanding_o !== 3'd0) begin n_fail++; $display("FAIL err_set: error=%b outstanding=%0d expected 1 0", error_o, outstanding_o); end
    step;
    step;
    n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: error=%b expected 1", error_o); end
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
    #1;
    n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: error=%b expected 0", error_o); end
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_raw;
    step;
    test_backpressure;
    test_full;
    test_int_wr;
    test_drain;
    test_error;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
